light_sequencer: RTL and testbench

Traffic-light controller that sits on the initiator side of the interval-timer interface. It requests intervals from the timer with a start/length pulse and consumes the timer's done pulse. It sequences the highway and farm-road lights, and serves the farm road only when a debounced car_detected request is pending.

---
 rtl/light_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_light_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_sequencer.sv
// Traffic-light sequencer: highway/farm-road lights driven from an external interval timer.
// Define ALL_RED_EN to insert all-red clearance states between the two roads' yellow and green.
module light_sequencer #(
    parameter int unsigned T_GREEN      = 30,
    parameter int unsigned T_YELLOW     = 5,
    parameter int unsigned T_SIDE_GREEN = 10,
    parameter int unsigned T_RED_CLR    = 2,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DEBOUNCE     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             car_detected,
    input  logic             tmr_done,
    output logic             tmr_start,
    output logic [CNT_W-1:0] tmr_len,
    output logic [2:0]       hwy_light,
    output logic [2:0]       farm_light,
    output logic             car_pending,
    output logic             proto_err,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        StHg  = 3'd0,
        StHy  = 3'd1,
        StFg  = 3'd2,
        StFy  = 3'd3,
        StAr1 = 3'd4,
        StAr2 = 3'd5
    } state_e;

    localparam longint unsigned LenLimit = 64'd1 << CNT_W;

    function automatic bit len_ok(input int unsigned t);
        return (t >= 1) && (64'(t) < LenLimit);
    endfunction

    localparam bit ParamsOk = (CNT_W >= 1) && (CNT_W <= 32) && (DEBOUNCE >= 1) &&
                              len_ok(T_GREEN) && len_ok(T_YELLOW) &&
                              len_ok(T_SIDE_GREEN) && len_ok(T_RED_CLR);

    if (!ParamsOk) begin : g_bad_params
        $error("light_sequencer: intervals must lie in [1, 2**CNT_W-1] and DEBOUNCE >= 1");
    end

    localparam logic [CNT_W-1:0] LenGreen  = CNT_W'(T_GREEN);
    localparam logic [CNT_W-1:0] LenYellow = CNT_W'(T_YELLOW);
    localparam logic [CNT_W-1:0] LenSide   = CNT_W'(T_SIDE_GREEN);
`ifdef ALL_RED_EN
    localparam logic [CNT_W-1:0] LenRedClr = CNT_W'(T_RED_CLR);
`endif

    localparam int unsigned      DbW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DbW-1:0]   DbLast = DbW'(DEBOUNCE - 1);

    logic           r_sync1;
    logic           r_sync2;
    logic [DbW-1:0] r_db_cnt;
    logic           r_car_valid;
    state_e         r_state;
    logic           r_start_req;
    logic           r_outstanding;
    logic           w_accept;
    logic           w_car_set;
    state_e         w_next_state;

    function automatic logic [CNT_W-1:0] interval_of(input state_e s);
        case (s)
            StHg:       return LenGreen;
            StHy, StFy: return LenYellow;
            StFg:       return LenSide;
`ifdef ALL_RED_EN
            default:    return LenRedClr;
`else
            default:    return LenGreen;
`endif
        endcase
    endfunction

    // Light encodings are {R,Y,G}.
    function automatic logic [2:0] hwy_of(input state_e s);
        case (s)
            StHg:    return 3'b001;
            StHy:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] farm_of(input state_e s);
        case (s)
            StFg:    return 3'b001;
            StFy:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Counter runs only while the synchronised level disagrees with the accepted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_db_cnt    <= '0;
            r_car_valid <= 1'b0;
        end else begin
            r_sync1 <= car_detected;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_car_valid) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DbLast) begin
                r_db_cnt    <= '0;
                r_car_valid <= r_sync2;
            end else begin
                r_db_cnt <= r_db_cnt + DbW'(1);
            end
        end
    end

    // A done pulse coincident with our own start pulse is never a valid completion.
    assign w_accept = tmr_done && r_outstanding && !tmr_start;

`ifdef ALL_RED_EN
    assign w_car_set = r_car_valid && (r_state == StHg || r_state == StHy || r_state == StAr1);
`else
    assign w_car_set = r_car_valid && (r_state == StHg || r_state == StHy);
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            StHg:    w_next_state = car_pending ? StHy : StHg;
`ifdef ALL_RED_EN
            StHy:    w_next_state = StAr1;
            StFy:    w_next_state = StAr2;
`else
            StHy:    w_next_state = StFg;
            StFy:    w_next_state = StHg;
`endif
            StFg:    w_next_state = StFy;
            StAr1:   w_next_state = StFg;
            StAr2:   w_next_state = StHg;
            default: w_next_state = StHg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StHg;
            hwy_light     <= 3'b001;
            farm_light    <= 3'b100;
            tmr_start     <= 1'b0;
            tmr_len       <= '0;
            car_pending   <= 1'b0;
            proto_err     <= 1'b0;
            r_start_req   <= 1'b1;
            r_outstanding <= 1'b0;
        end else begin
            tmr_start   <= r_start_req;
            r_start_req <= 1'b0;
            if (r_start_req) begin
                tmr_len       <= interval_of(r_state);
                r_outstanding <= 1'b1;
            end
            if (tmr_done && !w_accept) begin
                proto_err <= 1'b1;
            end
            if (w_car_set) begin
                car_pending <= 1'b1;
            end
            // Later assignments win, so entering FG clears a coincident set.
            if (w_accept) begin
                r_outstanding <= 1'b0;
                r_start_req   <= 1'b1;
                r_state       <= w_next_state;
                hwy_light     <= hwy_of(w_next_state);
                farm_light    <= farm_of(w_next_state);
                if (w_next_state == StFg) begin
                    car_pending <= 1'b0;
                end
            end
        end
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer: a cycle model predicts each timer request into a
// scoreboard queue; the bench plays the interval timer. Honours ALL_RED_EN when defined.
module tb_light_sequencer;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             car_detected = 1'b0;
    logic             tmr_done = 1'b0;
    logic             tmr_start;
    logic [CNT_W-1:0] tmr_len;
    logic [2:0]       hwy_light;
    logic [2:0]       farm_light;
    logic             car_pending;
    logic             proto_err;
    logic [2:0]       state_o;

    always #5 clk = ~clk;

    light_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .car_detected (car_detected),
        .tmr_done     (tmr_done),
        .tmr_start    (tmr_start),
        .tmr_len      (tmr_len),
        .hwy_light    (hwy_light),
        .farm_light   (farm_light),
        .car_pending  (car_pending),
        .proto_err    (proto_err),
        .state_o      (state_o)
    );

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] len;
        logic [2:0] hwy;
        logic [2:0] farm;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [2:0] m_state;
    bit         m_start_req, m_tstart, m_outst, m_pending, m_valid, m_perr;
    bit [4:0]   m_hist;

    // Bench timer and stimulus state
    bit tm_active, last_fire, inj_on_start, inj_after_done, car_val, saw_hy;
    int tm_cd;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] next_of(input logic [2:0] s, input bit pend);
        case (s)
            3'd0: return pend ? 3'd1 : 3'd0;
`ifdef ALL_RED_EN
            3'd1: return 3'd4;
            3'd3: return 3'd5;
`else
            3'd1: return 3'd2;
            3'd3: return 3'd0;
`endif
            3'd2: return 3'd3;
            3'd4: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] len_of(input logic [2:0] s);
        case (s)
            3'd0: return 8'd30;
            3'd1, 3'd3: return 8'd5;
            3'd2: return 8'd10;
            default: return 8'd2;
        endcase
    endfunction

    function automatic logic [2:0] hwy_of(input logic [2:0] s);
        if (s == 3'd0) return 3'b001;
        if (s == 3'd1) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] farm_of(input logic [2:0] s);
        if (s == 3'd2) return 3'b001;
        if (s == 3'd3) return 3'b010;
        return 3'b100;
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] s);
        exp_t e;
        e.st   = s;
        e.len  = len_of(s);
        e.hwy  = hwy_of(s);
        e.farm = farm_of(s);
        return e;
    endfunction

    task automatic model_reset();
        m_state     = 3'd0;
        m_start_req = 1'b1;
        m_tstart    = 1'b0;
        m_outst     = 1'b0;
        m_pending   = 1'b0;
        m_valid     = 1'b0;
        m_perr      = 1'b0;
        m_hist      = '0;
        sb_q.delete();
        sb_q.push_back(mk_exp(3'd0));
    endtask

    // Advance the model by one clock edge using the inputs held across that edge.
    task automatic model_edge();
        bit         acc, v_old;
        logic [2:0] nxt;
        acc   = tmr_done && m_outst && !m_tstart;
        nxt   = acc ? next_of(m_state, m_pending) : m_state;
        v_old = m_valid;
        m_hist = {m_hist[3:0], car_detected};
        if (m_hist[2] == m_hist[3] && m_hist[3] == m_hist[4]) m_valid = m_hist[2];
        if (acc && nxt == 3'd2) m_pending = 1'b0;
        else if (v_old && (m_state == 3'd0 || m_state == 3'd1 || m_state == 3'd4))
            m_pending = 1'b1;
        if (tmr_done && !acc) m_perr = 1'b1;
        m_tstart = m_start_req;
        if (m_start_req) m_outst = 1'b1;
        else if (acc) m_outst = 1'b0;
        m_start_req = acc;
        if (acc) sb_q.push_back(mk_exp(nxt));
        m_state = nxt;
    endtask

    task automatic check_outputs();
        exp_t e;
        check_eq("tmr_start", tmr_start, m_tstart);
        if (tmr_start) begin
            check_eq("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("start_state", state_o, e.st);
                check_eq("tmr_len", tmr_len, e.len);
                check_eq("start_hwy", hwy_light, e.hwy);
                check_eq("start_farm", farm_light, e.farm);
            end
        end
        check_eq("state_o", state_o, m_state);
        check_eq("hwy_light", hwy_light, hwy_of(m_state));
        check_eq("farm_light", farm_light, farm_of(m_state));
        check_eq("car_pending", car_pending, m_pending);
        check_eq("proto_err", proto_err, m_perr);
    endtask

    task automatic check_reset_values();
        check_eq("rst_state", state_o, 3'd0);
        check_eq("rst_hwy", hwy_light, 3'b001);
        check_eq("rst_farm", farm_light, 3'b100);
        check_eq("rst_tmr_start", tmr_start, 1'b0);
        check_eq("rst_tmr_len", tmr_len, 8'd0);
        check_eq("rst_car_pending", car_pending, 1'b0);
        check_eq("rst_proto_err", proto_err, 1'b0);
    endtask

    // One clock: model the edge, compare, then drive inputs for the next cycle.
    task automatic step();
        bit fire;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        fire = 1'b0;
        if (tmr_start) begin
            tm_active = 1'b1;
            tm_cd     = int'(tmr_len) - 1;
        end else if (tm_active) begin
            tm_cd--;
            if (tm_cd <= 0) begin
                fire      = 1'b1;
                tm_active = 1'b0;
            end
        end
        tmr_done = fire;
        if (inj_on_start && tmr_start) begin
            tmr_done     = 1'b1;
            inj_on_start = 1'b0;
        end
        if (inj_after_done && last_fire) begin
            tmr_done       = 1'b1;
            inj_after_done = 1'b0;
        end
        last_fire    = fire;
        car_detected = car_val;
    endtask

    initial begin
        model_reset();
        tm_active = 0; last_fire = 0; inj_on_start = 0; inj_after_done = 0; car_val = 0;
        #8;
        check_reset_values();
        #4 rst_n = 1'b1;

        // Idle highway green, repeated 30-tick requests
        repeat (70) step();

        // Car held: HG -> HY -> FG -> FY -> HG
        car_val = 1'b1;
        repeat (120) step();
        car_val = 1'b0;
        repeat (150) step();

        // Two-cycle glitch must be filtered
        car_val = 1'b1;
        step();
        step();
        car_val = 1'b0;
        saw_hy  = 1'b0;
        repeat (80) begin
            step();
            if (state_o == 3'd1) saw_hy = 1'b1;
        end
        check_eq("glitch_no_hy", saw_hy, 1'b0);
        check_eq("glitch_no_pending", car_pending, 1'b0);

        // Spurious done: coincident with start, and with nothing outstanding
        inj_on_start   = 1'b1;
        inj_after_done = 1'b1;
        repeat (80) step();
        check_eq("proto_err_sticky", proto_err, 1'b1);

        // Reset in the middle of FG
        car_val = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (m_state == 3'd2) break;
            step();
        end
        check_eq("reached_fg", state_o, 3'd2);
        repeat (4) step();
        tmr_done     = 1'b0;
        car_val      = 1'b0;
        car_detected = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        model_reset();
        tm_active = 0;
        last_fire = 0;
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
